stdcell_test_sequencer: RTL and testbench

STDCELL_TEST_SEQUENCER -- requirements
Module: stdcell_test_sequencer

---
 rtl/stdcell_seq_pkg.sv | 33 +++
 rtl/stdcell_test_sequencer.sv | 131 +++++++++++++
 tb/tb_stdcell_test_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/stdcell_seq_pkg.sv
// Shared types and constants for the standard-cell test sequencer.
// State encoding, GPIO status codes and default widths.
package stdcell_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SETTLE,
        S_COMPARE,
        S_PASS,
        S_FAIL
    } state_t;

    localparam logic [7:0] ST_IDLE = 8'h00;
    localparam logic [7:0] ST_BUSY = 8'h5A;
    localparam logic [7:0] ST_PASS = 8'hFE;
    localparam logic [7:0] ST_FAIL = 8'hEE;

    localparam int VEC_W_DEF  = 8;
    localparam int RES_W_DEF  = 8;
    localparam int ADDR_W_DEF = 8;

    function automatic logic [7:0] status_code(state_t s);
        case (s)
            S_IDLE:  return ST_IDLE;
            S_PASS:  return ST_PASS;
            S_FAIL:  return ST_FAIL;
            default: return ST_BUSY;
        endcase
    endfunction

endpackage

// File: rtl/stdcell_test_sequencer.sv
// Applies stored stimulus vectors to cells under test and compares
// the settled responses against stored expected values.
module stdcell_test_sequencer
    import stdcell_seq_pkg::*;
#(
    parameter int VEC_W  = VEC_W_DEF,
    parameter int RES_W  = RES_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   stop_on_fail,
    input  logic [ADDR_W-1:0]      num_vec,
    input  logic [3:0]             settle_cycles,
    output logic                   vec_rd,
    output logic [ADDR_W-1:0]      vec_addr,
    input  logic [VEC_W+RES_W-1:0] vec_data,
    output logic [VEC_W-1:0]       cut_in,
    input  logic [RES_W-1:0]       cut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDR_W-1:0]      fail_index,
    output logic [7:0]             err_cnt,
    output logic [7:0]             status
);

    state_t state, nxt;

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] num_q;
    logic [3:0]        settle_q;
    logic [3:0]        cnt;
    logic              sof_q;
    logic [RES_W-1:0]  exp_q;

    logic idle_like;
    logic start_ok;
    logic mismatch;
    logic last_vec;
    logic fail_now;

    assign idle_like = (state == S_IDLE) || (state == S_PASS) ||
                       (state == S_FAIL);
    assign start_ok  = start && idle_like && !abort;
    assign mismatch  = (cut_out != exp_q);
    assign last_vec  = (idx == num_q - 1'b1);
    assign fail_now  = fail || mismatch;

    assign vec_rd   = (state == S_FETCH) && !abort;
    assign vec_addr = idx;
    assign busy     = (state == S_FETCH) || (state == S_LOAD) ||
                      (state == S_SETTLE) || (state == S_COMPARE);
    assign done     = (state == S_PASS) || (state == S_FAIL);

    always_ff @(posedge clock) begin
        if (!resetb) state <= S_IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE, S_PASS, S_FAIL: begin
                if (start) nxt = (num_vec == '0) ? S_PASS : S_FETCH;
            end
            S_FETCH: nxt = S_LOAD;
            S_LOAD:  nxt = S_SETTLE;
            S_SETTLE: begin
                if (cnt == 4'd1) nxt = S_COMPARE;
            end
            S_COMPARE: begin
                if (mismatch && sof_q) nxt = S_FAIL;
                else if (last_vec)     nxt = fail_now ? S_FAIL : S_PASS;
                else                   nxt = S_FETCH;
            end
            default: nxt = S_IDLE;
        endcase
        if (abort) nxt = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            idx        <= '0;
            num_q      <= '0;
            settle_q   <= '0;
            sof_q      <= 1'b0;
            cnt        <= '0;
            exp_q      <= '0;
            cut_in     <= '0;
            fail       <= 1'b0;
            fail_index <= '0;
            err_cnt    <= '0;
            status     <= ST_IDLE;
        end else begin
            status <= status_code(state);
            if (abort) begin
                cut_in <= '0;
            end else if (start_ok) begin
                num_q      <= num_vec;
                settle_q   <= settle_cycles;
                sof_q      <= stop_on_fail;
                idx        <= '0;
                fail       <= 1'b0;
                fail_index <= '0;
                err_cnt    <= '0;
            end else begin
                unique case (state)
                    S_LOAD: begin
                        cut_in <= vec_data[VEC_W+RES_W-1:RES_W];
                        exp_q  <= vec_data[RES_W-1:0];
                        cnt    <= (settle_q == 4'd0) ? 4'd1 : settle_q;
                    end
                    S_SETTLE: cnt <= cnt - 4'd1;
                    S_COMPARE: begin
                        if (mismatch) begin
                            fail <= 1'b1;
                            if (!fail) fail_index <= idx;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end
                        if (nxt == S_FETCH) idx <= idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stdcell_test_sequencer.sv
// Scoreboard bench: expected vector reads and run results are queued
// at stimulus time and compared as the sequencer produces them.
module tb_stdcell_test_sequencer;

    logic        clock;
    logic        resetb;
    logic        start;
    logic        abort;
    logic        stop_on_fail;
    logic [7:0]  num_vec;
    logic [3:0]  settle_cycles;
    logic        vec_rd;
    logic [7:0]  vec_addr;
    logic [15:0] vec_data;
    logic [7:0]  cut_in;
    logic [7:0]  cut_out;
    logic        busy;
    logic        done;
    logic        fail;
    logic [7:0]  fail_index;
    logic [7:0]  err_cnt;
    logic [7:0]  status;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rd = -1;
    int exp_gap = 0;

    logic [15:0] mem [256];
    logic [7:0]  exp_addr [$];

    stdcell_test_sequencer #(
        .VEC_W(8), .RES_W(8), .ADDR_W(8)
    ) dut (
        .clock(clock), .resetb(resetb), .start(start), .abort(abort),
        .stop_on_fail(stop_on_fail), .num_vec(num_vec),
        .settle_cycles(settle_cycles), .vec_rd(vec_rd),
        .vec_addr(vec_addr), .vec_data(vec_data), .cut_in(cut_in),
        .cut_out(cut_out), .busy(busy), .done(done), .fail(fail),
        .fail_index(fail_index), .err_cnt(err_cnt), .status(status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cells under test: a fixed XOR of the stimulus.
    assign cut_out = cut_in ^ 8'hA5;

    always @(posedge clock) begin
        if (vec_rd) vec_data <= mem[vec_addr];
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (vec_rd) begin
            if (exp_addr.size() == 0) check("extra_rd", 1, 0);
            else check("rd_addr", vec_addr, exp_addr.pop_front());
            if (last_rd >= 0) check("rd_gap", cyc - last_rd, exp_gap);
            last_rd = cyc;
        end else if (!busy) begin
            last_rd = -1;
        end
    end

    task automatic check_reset_vals();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_fidx", fail_index, 0);
        check("rst_err", err_cnt, 0);
        check("rst_status", status, 8'h00);
        check("rst_cut_in", cut_in, 0);
        check("rst_vec_rd", vec_rd, 0);
        check("rst_vec_addr", vec_addr, 0);
    endtask

    task automatic run(int n, int s, bit sof, bit [255:0] bad);
        bit       ef = 0;
        int       efi = 0;
        int       eerr = 0;
        logic [7:0] stim;
        logic [7:0] last_stim = 8'h00;
        int       t = 0;
        exp_gap = ((s == 0) ? 1 : s) + 3;
        for (int i = 0; i < n; i++) begin
            stim = 8'($urandom_range(0, 255));
            mem[i] = {stim, stim ^ 8'hA5 ^ {7'd0, bad[i]}};
        end
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(8'(i));
            last_stim = mem[i][15:8];
            if (bad[i]) begin
                if (!ef) efi = i;
                ef = 1;
                eerr++;
                if (sof) break;
            end
        end
        num_vec = 8'(n);
        settle_cycles = 4'(s);
        stop_on_fail = sof;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        num_vec = 8'hC3;
        settle_cycles = 4'hF;
        stop_on_fail = ~sof;
        if (n == 0) check("zero_vec_done", done, 1);
        while (!done && t < 4000) begin
            @(negedge clock);
            t++;
        end
        check("run_done", done, 1);
        check("run_busy", busy, 0);
        check("run_fail", fail, ef);
        check("run_fidx", fail_index, efi);
        check("run_err", err_cnt, eerr);
        if (n != 0) check("run_cut_hold", cut_in, last_stim);
        @(negedge clock);
        check("run_status", status, ef ? 8'hEE : 8'hFE);
        check("run_rd_left", exp_addr.size(), 0);
    endtask

    task automatic wait_rd(logic [7:0] a);
        int t = 0;
        while (!(vec_rd && vec_addr == a) && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("wait_rd", 32'(vec_rd && vec_addr == a), 1);
    endtask

    initial begin
        bit [255:0] b;
        resetb = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        stop_on_fail = 1'b0;
        num_vec = '0;
        settle_cycles = '0;
        repeat (3) @(negedge clock);
        check_reset_vals();
        resetb = 1'b1;
        @(negedge clock);

        b = '0;
        run(3, 2, 0, b);
        b = '0; b[2] = 1;
        run(4, 2, 1, b);
        b = '0; b[1] = 1; b[3] = 1;
        run(4, 2, 0, b);
        b = '0;
        run(0, 2, 0, b);
        run(3, 0, 0, b);

        // Abort in SETTLE of vector 1, with a stray start while busy.
        b = '0; b[0] = 1;
        for (int i = 0; i < 4; i++) mem[i] = {8'(i), 8'(i) ^ 8'hA5 ^ {7'd0, b[i]}};
        exp_addr.push_back(8'd0);
        exp_addr.push_back(8'd1);
        exp_gap = 8;
        num_vec = 8'd4;
        settle_cycles = 4'd5;
        stop_on_fail = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_rd(8'd1);
        repeat (2) @(negedge clock);
        start = 1'b1;
        num_vec = 8'd0;
        @(negedge clock);
        start = 1'b0;
        check("ign_busy", busy, 1);
        check("ign_idx", vec_addr, 1);
        check("ign_done", done, 0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cut_in", cut_in, 0);
        check("abort_vec_rd", vec_rd, 0);
        @(negedge clock);
        check("abort_status", status, 8'h00);
        check("abort_fail", fail, 1);
        check("abort_err", err_cnt, 1);
        check("abort_fidx", fail_index, 0);
        check("abort_rd_left", exp_addr.size(), 0);

        // Reset in the middle of a run.
        for (int i = 0; i < 3; i++) mem[i] = {8'h11, 8'h11 ^ 8'hA5};
        exp_addr.push_back(8'd0);
        exp_gap = 5;
        num_vec = 8'd3;
        settle_cycles = 4'd2;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_rd(8'd0);
        repeat (2) @(negedge clock);
        resetb = 1'b0;
        @(negedge clock);
        check_reset_vals();
        @(negedge clock);
        check("rst_hold_rd", vec_rd, 0);
        resetb = 1'b1;
        b = '0;
        run(3, 2, 0, b);

        b = '0; b[254] = 1;
        run(255, 0, 1, b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
